// File: rtl/spart_pkg.sv
// Shared definitions for the serial keyboard receiver and the CPU decode
// stage that consumes its key codes.
package spart_pkg;

    // Key codes presented on SPART_keys; 0 means no key since reset.
    localparam logic [3:0] KEY_NONE   = 4'h0;
    localparam logic [3:0] KEY_UP     = 4'h1;  // 'w'
    localparam logic [3:0] KEY_DOWN   = 4'h2;  // 's'
    localparam logic [3:0] KEY_LEFT   = 4'h3;  // 'a'
    localparam logic [3:0] KEY_RIGHT  = 4'h4;  // 'd'
    localparam logic [3:0] KEY_ROT_L  = 4'h5;  // 'q'
    localparam logic [3:0] KEY_ROT_R  = 4'h6;  // 'e'
    localparam logic [3:0] KEY_JUMP   = 4'h7;  // space
    localparam logic [3:0] KEY_ENTER  = 4'h8;  // carriage return
    localparam logic [3:0] KEY_FIRE1  = 4'h9;  // 'r'
    localparam logic [3:0] KEY_FIRE2  = 4'hA;  // 'f'

    // Receiver frame states.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } rx_state_t;

    // Decoded keystroke: valid is clear for unmapped bytes.
    typedef struct packed {
        logic       valid;
        logic [3:0] code;
    } key_t;

    // Map an ASCII byte to a key code; letters are matched case-insensitively.
    function automatic key_t key_decode(input logic [7:0] b);
        logic [7:0] lc;
        key_t       k;
        lc = b;
        if (b >= 8'h41 && b <= 8'h5A) begin
            lc = b | 8'h20;
        end
        k.valid = 1'b1;
        k.code  = KEY_NONE;
        case (lc)
            8'h77:   k.code = KEY_UP;
            8'h73:   k.code = KEY_DOWN;
            8'h61:   k.code = KEY_LEFT;
            8'h64:   k.code = KEY_RIGHT;
            8'h71:   k.code = KEY_ROT_L;
            8'h65:   k.code = KEY_ROT_R;
            8'h20:   k.code = KEY_JUMP;
            8'h0D:   k.code = KEY_ENTER;
            8'h72:   k.code = KEY_FIRE1;
            8'h66:   k.code = KEY_FIRE2;
            default: k.valid = 1'b0;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/spart_key_rx_if.sv
// Serial line in, key strobe/code and framing-error pulse out.
interface spart_key_rx_if;
    import spart_pkg::*;

    logic       rxd;
    logic       SPART_we;
    logic [3:0] SPART_keys;
    logic       frame_err;

    // Host side: drives the line, observes the decoded keys.
    modport master (
        output rxd,
        input  SPART_we,
        input  SPART_keys,
        input  frame_err
    );

    // Receiver side.
    modport slave (
        input  rxd,
        output SPART_we,
        output SPART_keys,
        output frame_err
    );
endinterface

// File: rtl/spart_sync2.sv
// Two-flop synchronizer for an asynchronous input whose idle level is high.
module spart_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta_p0;
    logic sync_p1;

    // Shift the async input through two flops; reset to the idle-high level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_p0 <= 1'b1;
            sync_p1 <= 1'b1;
        end else begin
            meta_p0 <= d;
            sync_p1 <= meta_p0;
        end
    end

    assign q = sync_p1;
endmodule

// File: rtl/spart_key_rx.sv
// 8N1 serial keyboard receiver: deserializes frames, maps keystrokes to
// 4-bit key codes and strobes them towards the CPU decode stage.
module spart_key_rx
    import spart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic          clk,
    input  logic          rst_n,
    spart_key_rx_if.slave bus
);
    localparam int              CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT - 1);

    logic             rxd_s;
    rx_state_t        state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       idx, idx_n;
    logic [7:0]       sh, sh_n;
    logic [3:0]       keys, keys_n;
    logic             we, we_n;
    logic             ferr, ferr_n;
    key_t             dec;

    spart_sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.rxd),
        .q     (rxd_s)
    );

    assign dec = key_decode(sh);

    // State, baud counter, shift register and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            idx   <= '0;
            sh    <= '0;
            keys  <= KEY_NONE;
            we    <= 1'b0;
            ferr  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            sh    <= sh_n;
            keys  <= keys_n;
            we    <= we_n;
            ferr  <= ferr_n;
        end
    end

    // Frame sequencing; every sample is taken on the cycle the counter reads 0.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        sh_n    = sh;
        keys_n  = keys;
        we_n    = 1'b0;
        ferr_n  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!rxd_s) begin
                    cnt_n   = HALF_BIT;
                    state_n = ST_START;
                end
            end
            ST_START: begin
                if (cnt == '0) begin
                    if (!rxd_s) begin
                        cnt_n   = FULL_BIT;
                        idx_n   = '0;
                        state_n = ST_DATA;
                    end else begin
                        // Line was high again at mid-start: a glitch, not a frame.
                        state_n = ST_IDLE;
                    end
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            ST_DATA: begin
                if (cnt == '0) begin
                    sh_n  = {rxd_s, sh[7:1]};
                    cnt_n = FULL_BIT;
                    idx_n = idx + 3'd1;
                    if (idx == 3'd7) begin
                        state_n = ST_STOP;
                    end
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            ST_STOP: begin
                if (cnt == '0) begin
                    if (rxd_s) begin
                        if (dec.valid) begin
                            keys_n = dec.code;
                            we_n   = 1'b1;
                        end
                        // Back to IDLE at mid-stop so a following start edge is caught.
                        state_n = ST_IDLE;
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = ST_BREAK;
                    end
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            ST_BREAK: begin
                // A held-low line must return high before another frame is accepted.
                if (rxd_s) begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign bus.SPART_we   = we;
    assign bus.SPART_keys = keys;
    assign bus.frame_err  = ferr;
endmodule
